// File: rtl/rover_pkg.sv
// rover_pkg: shared state encoding for the motor-protection and display blocks
package rover_pkg;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_LOCKOUT  = 2'd3
  } oc_state_e;
endpackage

// File: rtl/oc_debounce.sv
// oc_debounce: 2-flop synchronizer plus saturating high-time counter for one comparator line
module oc_debounce #(
  parameter int DEBOUNCE_CYC = 1000,
  parameter int DEB_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic oc_i,
  output logic trip_o
);
  localparam logic [DEB_W-1:0] CNT_MAX = DEB_W'(DEBOUNCE_CYC - 1);
  logic [1:0] sync_q;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic s;
  assign s      = sync_q[1];
  assign cnt_d  = !s ? '0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + DEB_W'(1);
  assign trip_o = s & (cnt_q == CNT_MAX);
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], oc_i};
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/overcurrent_monitor.sv
// overcurrent_monitor: debounced overcurrent trip, cool-down/retry/lockout sequencing and PWM enable gating
module overcurrent_monitor #(
  parameter int DEBOUNCE_CYC = 1000,
  parameter int DEB_W        = 16,
  parameter int COOLDOWN_CYC = 50000000,
  parameter int COOL_W       = 26,
  parameter int MAX_RETRIES  = 3,
  parameter int RETRY_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               oc_a,
  input  logic               oc_b,
  input  logic               en_req,
  input  logic               pwm_in,
  input  logic               clear,
  output logic               en_a,
  output logic               en_b,
  output logic               fault_a,
  output logic               fault_b,
  output logic [1:0]         state,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               lockout
);
  import rover_pkg::*;
  localparam logic [COOL_W-1:0]  TMR_MAX   = COOL_W'(COOLDOWN_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
  oc_state_e state_q, state_d;
  logic [COOL_W-1:0] timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic fault_a_q, fault_a_d, fault_b_q, fault_b_d;
  logic en_q, en_d, lockout_q, lockout_d;
  logic trip_a, trip_b, trip, in_run, tmr_done;
  oc_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .DEB_W(DEB_W)) u_deb_a (
    .clk(clk), .rst(rst), .oc_i(oc_a), .trip_o(trip_a)
  );
  oc_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .DEB_W(DEB_W)) u_deb_b (
    .clk(clk), .rst(rst), .oc_i(oc_b), .trip_o(trip_b)
  );
  assign trip     = trip_a | trip_b;
  assign in_run   = state_q == ST_RUN;
  assign tmr_done = timer_q == TMR_MAX;
  // The single timer serves as cool-down counter in COOLDOWN and healthy-run counter in RUN
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    case (state_q)
      ST_IDLE: begin
        retry_d = '0;
        if (en_req) begin
          state_d = ST_RUN;
          timer_d = '0;
        end
      end
      ST_RUN: begin
        if (trip) begin
          state_d = (retry_q == RETRY_MAX) ? ST_LOCKOUT : ST_COOLDOWN;
          retry_d = (retry_q == RETRY_MAX) ? retry_q : retry_q + RETRY_W'(1);
          timer_d = '0;
        end else if (!en_req) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end else begin
          timer_d = tmr_done ? '0 : timer_q + COOL_W'(1);
          retry_d = tmr_done ? '0 : retry_q;
        end
      end
      ST_COOLDOWN: begin
        timer_d = tmr_done ? '0 : timer_q + COOL_W'(1);
        if (tmr_done) begin
          state_d = en_req ? ST_RUN : ST_IDLE;
          retry_d = en_req ? retry_q : '0;
        end
      end
      ST_LOCKOUT: begin
        if (clear && !en_req) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end
      end
    endcase
  end
  assign fault_a_d = (in_run & trip_a) | (fault_a_q & ~clear);
  assign fault_b_d = (in_run & trip_b) | (fault_b_q & ~clear);
  assign en_d      = (state_d == ST_RUN) & pwm_in;
  assign lockout_d = state_d == ST_LOCKOUT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      retry_q   <= '0;
      fault_a_q <= 1'b0;
      fault_b_q <= 1'b0;
      en_q      <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      fault_a_q <= fault_a_d;
      fault_b_q <= fault_b_d;
      en_q      <= en_d;
      lockout_q <= lockout_d;
    end
  end
  assign en_a      = en_q;
  assign en_b      = en_q;
  assign fault_a   = fault_a_q;
  assign fault_b   = fault_b_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;
  assign lockout   = lockout_q;
endmodule
